// File: rtl/dmx_tx_gen_pkg.sv
// dmx_tx_gen_pkg: shared definitions for the DMX512 transmitter.
// FSM state encodings, CSR register offsets, CTRL bit positions and the
// slot-count clamp helper.
package dmx_tx_gen_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_BREAK     = 3'd1;
   localparam logic [2:0] ST_MAB       = 3'd2;
   localparam logic [2:0] ST_SLOT      = 3'd3;
   localparam logic [2:0] ST_SLOT_STOP = 3'd4;
   localparam logic [2:0] ST_MTBP      = 3'd5;

   localparam logic [2:0] REG_CTRL   = 3'd0;
   localparam logic [2:0] REG_START  = 3'd1;
   localparam logic [2:0] REG_NCHAN  = 3'd2;
   localparam logic [2:0] REG_MTBP   = 3'd3;
   localparam logic [2:0] REG_STATUS = 3'd4;

   localparam int unsigned CTRL_THRU_EN  = 0;
   localparam int unsigned CTRL_ENABLE   = 1;
   localparam int unsigned CTRL_ONESHOT  = 2;
   localparam int unsigned CTRL_IRQ_MASK = 3;

   // 0 slots means 1; anything above the RAM depth is limited to it
   function automatic logic [9:0] clamp_nchan(input logic [9:0] n, input logic [9:0] max_n);
      if (n == 10'd0) return 10'd1;
      if (n > max_n) return max_n;
      return n;
   endfunction

endpackage

// File: rtl/dmx_tx_ram.sv
// dmx_tx_ram: channel RAM, depth x 8, port A CSR read/write,
// port B generator read-only, both with 1-cycle synchronous read.
// Reads return the old byte when written in the same cycle.
module dmx_tx_ram #(
   parameter int unsigned depth = 512,
   parameter int unsigned aw    = 9
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic          a_we,
   input  logic [aw-1:0] a_addr,
   input  logic [7:0]    a_di,
   output logic [7:0]    a_do,
   input  logic          b_en,
   input  logic [aw-1:0] b_addr,
   output logic [7:0]    b_do
);

   logic [7:0] mem [depth];

   // storage array, written from the CSR port only
   always_ff @(posedge sys_clk) begin
      if (a_we) mem[a_addr] <= a_di;
   end

   // registered read ports
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         a_do <= '0;
         b_do <= '0;
      end else begin
         a_do <= mem[a_addr];
         if (b_en) b_do <= mem[b_addr];
      end
   end

endmodule

// File: rtl/dmx_tx_gen.sv
// dmx_tx_gen: DMX512 transmitter. BREAK, MAB, start-code slot, then NCHAN
// channel slots from the channel RAM, with optional MTBP between frames.
// Build option: DMX_TX_IRQ_EN adds the irq port and CTRL[3] irq_mask.
module dmx_tx_gen
   import dmx_tx_gen_pkg::*;
#(
   parameter logic [4:0]  csr_addr     = 5'h00,
   parameter int unsigned clk_freq     = 100000000,
   parameter int unsigned baud         = 250000,
   parameter int unsigned max_channels = 512,
   parameter int unsigned break_bits   = 22,
   parameter int unsigned mab_bits     = 3
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [14:0] csr_a,
   input  logic        csr_we,
   input  logic [31:0] csr_di,
   output logic [31:0] csr_do,
   input  logic        thru,
   output logic        tx
`ifdef DMX_TX_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int unsigned aw         = $clog2(max_channels);
   localparam int unsigned bit_period = clk_freq / baud;

   logic [31:0] tick_cnt;
   logic        tick;
   logic        csr_sel, reg_we, ram_we;
   logic        ctrl_thru_en, ctrl_enable, ctrl_oneshot, ctrl_irq_mask;
   logic [7:0]  start_code;
   logic [9:0]  nchan;
   logic [15:0] mtbp;
   logic [15:0] frame_count;
   logic [31:0] reg_rd, csr_reg_q;
   logic        sel_ram_q;
   logic [7:0]  ram_a_do, ram_b_do;
   logic        ram_b_en;
   logic [2:0]  state, state_nx;
   logic [15:0] bit_cnt;
   logic [9:0]  slot_idx;
   logic [8:0]  shift;
   logic [7:0]  start_s;
   logic [9:0]  nchan_s;
   logic [15:0] mtbp_s;
   logic        frame_done, frame_end, tx_gen;
   logic        unused_bits;

   assign csr_sel     = (csr_a[14:10] == csr_addr);
   assign reg_we      = csr_we && csr_sel && csr_a[9];
   assign ram_we      = csr_we && csr_sel && !csr_a[9];
   assign tick        = (tick_cnt == '0);
   assign frame_end   = tick && frame_done;
   assign ram_b_en    = tick && (state == ST_SLOT_STOP) && (bit_cnt == 16'd1);
   assign unused_bits = ^{csr_di[31:16], csr_a[8:0], slot_idx};

   // free-running bit-period tick
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) tick_cnt <= 32'(bit_period - 1);
      else if (tick)  tick_cnt <= 32'(bit_period - 1);
      else            tick_cnt <= tick_cnt - 32'd1;
   end

   // CSR registers, frame counter and one-shot self-clear
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ctrl_thru_en <= 1'b0;
         ctrl_enable  <= 1'b0;
         ctrl_oneshot <= 1'b0;
         start_code   <= '0;
         nchan        <= 10'(max_channels);
         mtbp         <= '0;
         frame_count  <= '0;
      end else begin
         if (frame_end) begin
            frame_count <= frame_count + 16'd1;
            if (ctrl_oneshot) begin
               ctrl_enable  <= 1'b0;
               ctrl_oneshot <= 1'b0;
            end
         end
         if (reg_we) begin
            case (csr_a[2:0])
               REG_CTRL: begin
                  ctrl_thru_en <= csr_di[CTRL_THRU_EN];
                  ctrl_enable  <= csr_di[CTRL_ENABLE];
                  ctrl_oneshot <= csr_di[CTRL_ONESHOT];
               end
               REG_START: start_code <= csr_di[7:0];
               REG_NCHAN: nchan      <= csr_di[9:0];
               REG_MTBP:  mtbp       <= csr_di[15:0];
               default: ;
            endcase
         end
      end
   end

`ifdef DMX_TX_IRQ_EN
   // interrupt mask bit and end-of-frame pulse
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ctrl_irq_mask <= 1'b0;
         irq           <= 1'b0;
      end else begin
         if (reg_we && (csr_a[2:0] == REG_CTRL)) ctrl_irq_mask <= csr_di[CTRL_IRQ_MASK];
         irq <= frame_end && !ctrl_irq_mask;
      end
   end
`else
   assign ctrl_irq_mask = 1'b0;
`endif

   // register read mux
   always_comb begin
      reg_rd = '0;
      case (csr_a[2:0])
         REG_CTRL:   reg_rd = {28'd0, ctrl_irq_mask, ctrl_oneshot, ctrl_enable, ctrl_thru_en};
         REG_START:  reg_rd = {24'd0, start_code};
         REG_NCHAN:  reg_rd = {22'd0, nchan};
         REG_MTBP:   reg_rd = {16'd0, mtbp};
         REG_STATUS: reg_rd = {frame_count, 15'd0, (state != ST_IDLE)};
         default:    reg_rd = '0;
      endcase
   end

   // registered read path; RAM data arrives from its own output register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         csr_reg_q <= '0;
         sel_ram_q <= 1'b0;
      end else begin
         csr_reg_q <= (csr_sel && csr_a[9]) ? reg_rd : '0;
         sel_ram_q <= csr_sel && !csr_a[9];
      end
   end

   assign csr_do = sel_ram_q ? {24'd0, ram_a_do} : csr_reg_q;

   dmx_tx_ram #(.depth(max_channels), .aw(aw)) u_ram (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .a_we     (ram_we),
      .a_addr   (csr_a[aw-1:0]),
      .a_di     (csr_di[7:0]),
      .a_do     (ram_a_do),
      .b_en     (ram_b_en),
      .b_addr   (slot_idx[aw-1:0]),
      .b_do     (ram_b_do)
   );

   // next-state decision, evaluated when the current bit counter expires
   always_comb begin
      state_nx   = state;
      frame_done = 1'b0;
      case (state)
         ST_IDLE:  if (ctrl_enable) state_nx = ST_BREAK;
         ST_BREAK: if (bit_cnt == '0) state_nx = ST_MAB;
         ST_MAB:   if (bit_cnt == '0) state_nx = ST_SLOT;
         ST_SLOT:  if (bit_cnt == '0) state_nx = ST_SLOT_STOP;
         ST_SLOT_STOP: begin
            if (bit_cnt == '0) begin
               if (slot_idx < nchan_s) state_nx = ST_SLOT;
               else begin
                  frame_done = 1'b1;
                  if (mtbp_s != '0)                      state_nx = ST_MTBP;
                  else if (ctrl_enable && !ctrl_oneshot) state_nx = ST_BREAK;
                  else                                   state_nx = ST_IDLE;
               end
            end
         end
         ST_MTBP:  if (bit_cnt == '0) state_nx = ctrl_enable ? ST_BREAK : ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // frame sequencer; every state entry is a state change, so counters and
   // shadows load on change and otherwise count down
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= ST_IDLE;
         bit_cnt  <= '0;
         slot_idx <= '0;
         shift    <= '1;
         start_s  <= '0;
         nchan_s  <= 10'(max_channels);
         mtbp_s   <= '0;
      end else if (tick) begin
         state <= state_nx;
         if (state_nx != state) begin
            case (state_nx)
               ST_BREAK: begin
                  bit_cnt <= 16'(break_bits - 1);
                  start_s <= start_code;
                  nchan_s <= clamp_nchan(nchan, 10'(max_channels));
                  mtbp_s  <= mtbp;
               end
               ST_MAB:  bit_cnt <= 16'(mab_bits - 1);
               ST_SLOT: begin
                  bit_cnt <= 16'd8;
                  if (state == ST_MAB) begin
                     shift    <= {start_s, 1'b0};
                     slot_idx <= '0;
                  end else begin
                     shift    <= {ram_b_do, 1'b0};
                     slot_idx <= slot_idx + 10'd1;
                  end
               end
               ST_SLOT_STOP: bit_cnt <= 16'd1;
               ST_MTBP:      bit_cnt <= mtbp_s - 16'd1;
               default:      bit_cnt <= '0;
            endcase
         end else if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 16'd1;
            if (state == ST_SLOT) shift <= {1'b1, shift[8:1]};
         end
      end
   end

   // line level from the sequencer, bypassed by pass-through
   always_comb begin
      tx_gen = 1'b1;
      if (state == ST_BREAK)     tx_gen = 1'b0;
      else if (state == ST_SLOT) tx_gen = shift[0];
   end

   assign tx = ctrl_thru_en ? thru : tx_gen;

endmodule

// File: tb/tb_dmx_tx_gen.sv
// tb_dmx_tx_gen: line decoder monitor + expected-event scoreboard for dmx_tx_gen,
// plus direct CSR and pass-through checks. clk_freq=1e6, baud=250k -> 4 cycles/bit.
module tb_dmx_tx_gen;

   localparam int EV_BRK = 0, EV_MAB = 1, EV_SLOT = 2;
   localparam logic [14:0] A_CTRL = 15'h200, A_START = 15'h201, A_NCHAN = 15'h202,
                           A_MTBP = 15'h203, A_STATUS = 15'h204;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic [14:0] csr_a = '0;
   logic        csr_we = 1'b0;
   logic [31:0] csr_di = '0;
   logic [31:0] csr_do;
   logic        thru = 1'b1;
   logic        tx;
`ifdef DMX_TX_IRQ_EN
   logic        irq;
   int          irq_cnt = 0;
`endif

   typedef struct { int kind; int val; } ev_t;
   ev_t  exp_q[$];
   int   tests = 0;
   int   fails = 0;
   logic mon_en = 1'b1;

   always #5 sys_clk = ~sys_clk;

   dmx_tx_gen #(.csr_addr(5'h00), .clk_freq(1000000), .baud(250000),
                .max_channels(512), .break_bits(22), .mab_bits(3)) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .csr_a    (csr_a),
      .csr_we   (csr_we),
      .csr_di   (csr_di),
      .csr_do   (csr_do),
      .thru     (thru),
      .tx       (tx)
`ifdef DMX_TX_IRQ_EN
      , .irq    (irq)
`endif
   );

`ifdef DMX_TX_IRQ_EN
   always @(negedge sys_clk) if (irq === 1'b1) irq_cnt++;
`endif

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic push_ev(int kind, int val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic push_hdr(int sc);
      push_ev(EV_BRK, 88);
      push_ev(EV_MAB, 12);
      push_ev(EV_SLOT, sc);
   endtask

   task automatic observe(int kind, int val);
      ev_t e;
      if (!mon_en) return;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL line_event: got kind %0d val %0h, expected no event", kind, val);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.val != val) begin
            fails++;
            $display("FAIL line_event: got kind %0d val %0h, expected kind %0d val %0h",
                     kind, val, e.kind, e.val);
         end
      end
   endtask

   // line decoder: a low run longer than a slot is a BREAK, else an 11-bit slot
   initial begin : monitor
      logic       prev;
      logic       fall;
      logic       s [44];
      logic [7:0] b;
      int         n;
      prev = 1'b1;
      fall = 1'b0;
      forever begin
         if (!fall) begin
            @(negedge sys_clk);
            fall = prev && !tx;
            prev = tx;
         end
         if (fall) begin
            fall = 1'b0;
            s[0] = tx;
            for (int i = 1; i < 44; i++) begin
               @(negedge sys_clk);
               s[i] = tx;
            end
            if (s[38] && s[42]) begin
               for (int j = 0; j < 8; j++) b[j] = s[6 + 4 * j];
               observe(EV_SLOT, int'(b));
               prev = s[43];
            end else begin
               n = 44;
               while (n < 1000) begin
                  @(negedge sys_clk);
                  if (tx) break;
                  n++;
               end
               observe(EV_BRK, n);
               n = 1;
               while (n < 1000) begin
                  @(negedge sys_clk);
                  if (!tx) break;
                  n++;
               end
               observe(EV_MAB, n);
               prev = tx;
               fall = !tx;
            end
         end
      end
   end

   task automatic csr_wr(logic [14:0] a, logic [31:0] d);
      @(negedge sys_clk);
      csr_a  = a;
      csr_di = d;
      csr_we = 1'b1;
      @(negedge sys_clk);
      csr_we = 1'b0;
   endtask

   task automatic csr_rd(logic [14:0] a, output logic [31:0] d);
      @(negedge sys_clk);
      csr_a  = a;
      csr_we = 1'b0;
      @(posedge sys_clk);
      #1 d = csr_do;
   endtask

   task automatic wait_drain(string name, int budget);
      int c = 0;
      while (exp_q.size() != 0 && c < budget) begin
         @(posedge sys_clk);
         c++;
      end
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic wait_busy(string name);
      logic [31:0] d;
      int c = 0;
      csr_rd(A_STATUS, d);
      while (!d[0] && c < 20) begin
         csr_rd(A_STATUS, d);
         c++;
      end
      check(name, {31'd0, d[0]}, 1);
   endtask

   task automatic wait_idle(string name);
      logic [31:0] d;
      int c = 0;
      csr_rd(A_STATUS, d);
      while (d[0] && c < 2000) begin
         csr_rd(A_STATUS, d);
         c++;
      end
      check(name, {31'd0, d[0]}, 0);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [31:0] d;
      int c;
`ifdef DMX_TX_IRQ_EN
      int i0;
`endif
      #23;
      check("reset_tx", {31'd0, tx}, 1);
      check("reset_csr_do", csr_do, 0);
      sys_rst_n = 1'b1;
      csr_rd(A_CTRL, d);    check("reset_ctrl", d, 0);
      csr_rd(A_START, d);   check("reset_start", d, 0);
      csr_rd(A_NCHAN, d);   check("reset_nchan", d, 512);
      csr_rd(A_MTBP, d);    check("reset_mtbp", d, 0);
      csr_rd(A_STATUS, d);  check("reset_status", d, 0);
      csr_rd(15'h205, d);   check("unmapped_reg", d, 0);

      // basic one-shot frame: 3 channels
      csr_wr(A_NCHAN, 3);
      csr_wr(15'h000, 32'h11);
      csr_wr(15'h001, 32'h22);
      csr_wr(15'h002, 32'h33);
      csr_wr(A_START, 0);
      csr_rd(15'h002, d);   check("ram_readback", d, 32'h33);
      csr_rd(15'h602, d);   check("other_page", d, 0);
      push_hdr(8'h00); push_ev(EV_SLOT, 8'h11); push_ev(EV_SLOT, 8'h22); push_ev(EV_SLOT, 8'h33);
      csr_wr(A_CTRL, 32'h6);
      wait_drain("frame1_done", 2000);
      wait_idle("frame1_idle");
      csr_rd(A_STATUS, d);  check("frame1_status", d, 32'h0001_0000);
      csr_rd(A_CTRL, d);    check("oneshot_cleared", d, 0);
      repeat (300) @(posedge sys_clk);
      #1 check("oneshot_tx_idle", {31'd0, tx}, 1);
      csr_rd(A_STATUS, d);  check("oneshot_single", d, 32'h0001_0000);

      // NCHAN written mid-frame applies to the following frame
      csr_wr(15'h003, 32'h44);
      csr_wr(15'h004, 32'h55);
      csr_wr(A_MTBP, 2);
      push_hdr(8'h00); push_ev(EV_SLOT, 8'h11); push_ev(EV_SLOT, 8'h22); push_ev(EV_SLOT, 8'h33);
      push_hdr(8'h00); push_ev(EV_SLOT, 8'h11); push_ev(EV_SLOT, 8'h22); push_ev(EV_SLOT, 8'h33);
      push_ev(EV_SLOT, 8'h44); push_ev(EV_SLOT, 8'h55);
      csr_wr(A_CTRL, 32'h2);
      wait_busy("cont_busy");
      repeat (200) @(posedge sys_clk);
      csr_wr(A_NCHAN, 5);
      c = 0;
      csr_rd(A_STATUS, d);
      while (d[31:16] != 16'd2 && c < 1000) begin
         csr_rd(A_STATUS, d);
         c++;
      end
      check("frameA_count", d[31:16], 2);
      repeat (30) @(posedge sys_clk);
      csr_wr(A_CTRL, 0);
      wait_drain("frameB_done", 3000);
      wait_idle("frameB_idle");
      csr_rd(A_STATUS, d);  check("frameB_status", d, 32'h0003_0000);

      // NCHAN=0 behaves as one channel
      csr_wr(A_MTBP, 0);
      csr_wr(A_NCHAN, 0);
      csr_wr(A_START, 32'hA5);
      push_hdr(8'hA5); push_ev(EV_SLOT, 8'h11);
      csr_wr(A_CTRL, 32'h6);
      wait_drain("nchan0_done", 2000);
      wait_idle("nchan0_idle");

      // NCHAN above the RAM depth is clamped to 512 slots
      for (int i = 0; i < 512; i++) csr_wr(15'(i), 32'((i * 7 + 3) & 255));
      csr_wr(A_NCHAN, 1000);
      csr_rd(A_NCHAN, d);   check("nchan_raw", d, 1000);
      csr_wr(A_START, 32'h5A);
      push_hdr(8'h5A);
      for (int i = 0; i < 512; i++) push_ev(EV_SLOT, (i * 7 + 3) & 255);
      csr_wr(A_CTRL, 32'h6);
      wait_drain("nchan_max_done", 30000);
      wait_idle("nchan_max_idle");
      csr_rd(A_STATUS, d);  check("nchan_max_status", d, 32'h0005_0000);

`ifdef DMX_TX_IRQ_EN
      csr_wr(A_NCHAN, 2);
      csr_wr(A_START, 0);
      i0 = irq_cnt;
      push_hdr(8'h00); push_ev(EV_SLOT, 8'h03); push_ev(EV_SLOT, 8'h0A);
      csr_wr(A_CTRL, 32'h6);
      wait_drain("irq_frame_done", 2000);
      wait_idle("irq_frame_idle");
      check("irq_one_pulse", irq_cnt - i0, 1);
      i0 = irq_cnt;
      push_hdr(8'h00); push_ev(EV_SLOT, 8'h03); push_ev(EV_SLOT, 8'h0A);
      csr_wr(A_CTRL, 32'hE);
      wait_drain("irq_mask_done", 2000);
      wait_idle("irq_mask_idle");
      check("irq_masked", irq_cnt - i0, 0);
      csr_rd(A_CTRL, d);    check("irq_mask_kept", d, 32'h8);
      csr_wr(A_CTRL, 0);
`else
      csr_wr(A_CTRL, 32'h8);
      csr_rd(A_CTRL, d);    check("ctrl3_ignored", d, 0);
`endif

      // pass-through: tx follows thru combinationally
      mon_en = 1'b0;
      csr_wr(A_CTRL, 32'h1);
      csr_rd(A_CTRL, d);    check("thru_ctrl", d, 1);
      @(negedge sys_clk);
      thru = 1'b0; #1 check("thru_low", {31'd0, tx}, 0);
      thru = 1'b1; #1 check("thru_high", {31'd0, tx}, 1);
      thru = 1'b0; #1 check("thru_low2", {31'd0, tx}, 0);
      csr_wr(A_CTRL, 0);
      #1 check("thru_off_gen", {31'd0, tx}, 1);
      thru = 1'b1;

      // asynchronous reset in the middle of the start-code slot
      csr_wr(A_NCHAN, 3);
      csr_wr(A_START, 0);
      csr_wr(A_CTRL, 32'h2);
      wait_busy("rst_busy");
      repeat (120) @(posedge sys_clk);
      @(negedge sys_clk);
      check("pre_rst_slot_low", {31'd0, tx}, 0);
      #1 sys_rst_n = 1'b0;
      #1 check("rst_tx_high", {31'd0, tx}, 1);
      check("rst_csr_do", csr_do, 0);
      repeat (3) @(posedge sys_clk);
      #2 sys_rst_n = 1'b1;
      csr_rd(A_CTRL, d);    check("post_rst_ctrl", d, 0);
      csr_rd(A_STATUS, d);  check("post_rst_status", d, 0);
      csr_rd(A_NCHAN, d);   check("post_rst_nchan", d, 512);

      check("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
